regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy/tag scoreboard, commit bypass and busy counter.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int TAGW = 4,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [XLEN-1:0]      wdata,
   input  logic [TAGW-1:0]      wtag,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic [TAGW-1:0]      iss_tag,
   input  logic                 flush,
   input  logic [NRD-1:0]       re,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*XLEN-1:0]  rdata,
   output logic [NRD-1:0]       rbusy,
   output logic [NRD*TAGW-1:0]  rtag,
   output logic [AW:0]          busy_cnt
);
   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [TAGW-1:0] tag_q [NREG];
   logic [TAGW-1:0] tag_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            iss_hit, com_clr, inc, dec;
   logic [AW-1:0]   a;
   logic            byp;

   assign iss_hit = iss_valid && !flush && iss_rd != '0;
   assign com_clr = we && waddr != '0 && busy_q[waddr] && tag_q[waddr] == wtag;
   assign inc     = iss_hit && !busy_q[iss_rd];
   assign dec     = com_clr && !(iss_hit && iss_rd == waddr);
   assign cnt_d   = flush ? '0 : cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
   assign busy_cnt = cnt_q;

   // Commit clears first so a same-cycle issue to the same register wins.
   always_comb begin
      regs_d = regs_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      if (we && waddr != '0) regs_d[waddr] = wdata;
      if (com_clr) busy_d[waddr] = 1'b0;
      if (iss_hit) begin
         busy_d[iss_rd] = 1'b1;
         tag_d[iss_rd]  = iss_tag;
      end
      if (flush) busy_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
         tag_q  <= '{default: '0};
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Reads see a same-cycle commit but never a same-cycle issue.
   always_comb begin
      rdata = '0;
      rbusy = '0;
      rtag  = '0;
      a     = '0;
      byp   = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         a   = raddr[i*AW +: AW];
         byp = we && waddr == a;
         if (!rst && re[i] && a != '0) begin
            rdata[i*XLEN +: XLEN] = byp ? wdata : regs_q[a];
            rbusy[i]              = busy_q[a] && !(byp && tag_q[a] == wtag);
            rtag[i*TAGW +: TAGW]  = tag_q[a];
         end
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus scoreboard fill/drain and mid-run reset sequences.
module tb_regfile_sb;
   logic        clk, rst, we, iss_valid, flush;
   logic [4:0]  waddr, iss_rd;
   logic [31:0] wdata;
   logic [3:0]  wtag, iss_tag;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic [7:0]  rtag;
   logic [5:0]  busy_cnt;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic we; logic [4:0] waddr; logic [31:0] wdata; logic [3:0] wtag;
      logic iv; logic [4:0] ird; logic [3:0] itag; logic fl;
      logic [1:0] re; logic [4:0] ra0; logic [4:0] ra1;
      logic [31:0] d0; logic b0; logic [3:0] t0;
      logic [31:0] d1; logic b1; logic [3:0] t1;
      logic [5:0] cnt;
   } vec_t;
   vec_t v [21];

   regfile_sb dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wtag(wtag),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag), .flush(flush),
      .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rtag(rtag),
      .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0; wtag = '0;
      iss_valid = 1'b0; iss_rd = '0; iss_tag = '0; flush = 1'b0;
      re = 2'b11; raddr = '0;
   endtask

   task automatic check_ports(input string n, input logic [31:0] d0, input logic b0, input logic [3:0] t0,
                              input logic [31:0] d1, input logic b1, input logic [3:0] t1, input logic [5:0] cnt);
      chk({n, ".d0"}, 64'(rdata[31:0]), 64'(d0));
      chk({n, ".b0"}, 64'(rbusy[0]), 64'(b0));
      chk({n, ".t0"}, 64'(rtag[3:0]), 64'(t0));
      chk({n, ".d1"}, 64'(rdata[63:32]), 64'(d1));
      chk({n, ".b1"}, 64'(rbusy[1]), 64'(b1));
      chk({n, ".t1"}, 64'(rtag[7:4]), 64'(t1));
      chk({n, ".cnt"}, 64'(busy_cnt), 64'(cnt));
   endtask

   initial begin
      v[0]  = '{1'b1,5'd5,32'hDEADBEEF,4'd0, 1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd5,5'd0,  32'hDEADBEEF,1'b0,4'd0, 32'h0,1'b0,4'd0, 6'd0};
      v[1]  = '{1'b1,5'd0,32'h1234,4'd0,     1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd5,5'd0,  32'hDEADBEEF,1'b0,4'd0, 32'h0,1'b0,4'd0, 6'd0};
      v[2]  = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd0,5'd5,  32'h0,1'b0,4'd0, 32'hDEADBEEF,1'b0,4'd0, 6'd0};
      v[3]  = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b00,5'd5,5'd5,  32'h0,1'b0,4'd0, 32'h0,1'b0,4'd0, 6'd0};
      v[4]  = '{1'b0,5'd0,32'h0,4'd0,        1'b1,5'd7,4'd3, 1'b0, 2'b11,5'd7,5'd5,  32'h0,1'b0,4'd0, 32'hDEADBEEF,1'b0,4'd0, 6'd0};
      v[5]  = '{1'b1,5'd7,32'h55,4'd3,       1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd7,5'd7,  32'h55,1'b0,4'd3, 32'h55,1'b0,4'd3, 6'd1};
      v[6]  = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b01,5'd7,5'd7,  32'h55,1'b0,4'd3, 32'h0,1'b0,4'd0, 6'd0};
      v[7]  = '{1'b0,5'd0,32'h0,4'd0,        1'b1,5'd7,4'd3, 1'b0, 2'b01,5'd7,5'd0,  32'h55,1'b0,4'd3, 32'h0,1'b0,4'd0, 6'd0};
      v[8]  = '{1'b0,5'd0,32'h0,4'd0,        1'b1,5'd7,4'd9, 1'b0, 2'b01,5'd7,5'd0,  32'h55,1'b1,4'd3, 32'h0,1'b0,4'd0, 6'd1};
      v[9]  = '{1'b1,5'd7,32'hAA,4'd3,       1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd7,5'd7,  32'hAA,1'b1,4'd9, 32'hAA,1'b1,4'd9, 6'd1};
      v[10] = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b01,5'd7,5'd0,  32'hAA,1'b1,4'd9, 32'h0,1'b0,4'd0, 6'd1};
      v[11] = '{1'b1,5'd7,32'hAB,4'd9,       1'b0,5'd0,4'd0, 1'b0, 2'b01,5'd7,5'd0,  32'hAB,1'b0,4'd9, 32'h0,1'b0,4'd0, 6'd1};
      v[12] = '{1'b1,5'd3,32'h33,4'd0,       1'b1,5'd2,4'd1, 1'b0, 2'b11,5'd2,5'd3,  32'h0,1'b0,4'd0, 32'h33,1'b0,4'd0, 6'd0};
      v[13] = '{1'b0,5'd0,32'h0,4'd0,        1'b1,5'd3,4'd2, 1'b0, 2'b11,5'd2,5'd3,  32'h0,1'b1,4'd1, 32'h33,1'b0,4'd0, 6'd1};
      v[14] = '{1'b0,5'd0,32'h0,4'd0,        1'b1,5'd4,4'd4, 1'b0, 2'b11,5'd3,5'd4,  32'h33,1'b1,4'd2, 32'h0,1'b0,4'd0, 6'd2};
      v[15] = '{1'b0,5'd0,32'h0,4'd0,        1'b1,5'd6,4'd5, 1'b1, 2'b11,5'd4,5'd6,  32'h0,1'b1,4'd4, 32'h0,1'b0,4'd0, 6'd3};
      v[16] = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd3,5'd6,  32'h33,1'b0,4'd2, 32'h0,1'b0,4'd0, 6'd0};
      v[17] = '{1'b1,5'd9,32'h77,4'd1,       1'b1,5'd9,4'd2, 1'b0, 2'b01,5'd9,5'd0,  32'h77,1'b0,4'd0, 32'h0,1'b0,4'd0, 6'd0};
      v[18] = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b11,5'd9,5'd3,  32'h77,1'b1,4'd2, 32'h33,1'b0,4'd2, 6'd1};
      v[19] = '{1'b1,5'd9,32'h99,4'd2,       1'b0,5'd0,4'd0, 1'b1, 2'b01,5'd9,5'd0,  32'h99,1'b0,4'd2, 32'h0,1'b0,4'd0, 6'd1};
      v[20] = '{1'b0,5'd0,32'h0,4'd0,        1'b0,5'd0,4'd0, 1'b0, 2'b01,5'd9,5'd0,  32'h99,1'b0,4'd2, 32'h0,1'b0,4'd0, 6'd0};

      idle();
      rst = 1'b1;
      raddr = {5'd7, 5'd5};
      @(negedge clk);
      @(negedge clk);
      #1 check_ports("in_reset", 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 6'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_ports("after_reset", 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 6'd0);

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         we = v[i].we; waddr = v[i].waddr; wdata = v[i].wdata; wtag = v[i].wtag;
         iss_valid = v[i].iv; iss_rd = v[i].ird; iss_tag = v[i].itag; flush = v[i].fl;
         re = v[i].re; raddr = {v[i].ra1, v[i].ra0};
         #1 check_ports($sformatf("vec%0d", i), v[i].d0, v[i].b0, v[i].t0, v[i].d1, v[i].b1, v[i].t1, v[i].cnt);
      end

      // Fill every register, then drain; counter must reach 31 and return to 0.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         idle();
         iss_valid = 1'b1; iss_rd = 5'(i); iss_tag = 4'(i);
         #1 chk($sformatf("fill%0d.cnt", i), 64'(busy_cnt), 64'(i - 1));
      end
      @(negedge clk);
      idle();
      iss_valid = 1'b1; iss_rd = 5'd1; iss_tag = 4'd7;
      raddr = {5'd0, 5'd31};
      #1 chk("full.cnt", 64'(busy_cnt), 64'd31);
      chk("full.b31", 64'(rbusy[0]), 64'd1);
      chk("full.t31", 64'(rtag[3:0]), 64'd15);
      @(negedge clk);
      idle();
      we = 1'b1; waddr = 5'd1; wdata = 32'h1; wtag = 4'd1;
      raddr = {5'd0, 5'd1};
      #1 chk("reissue.cnt", 64'(busy_cnt), 64'd31);
      chk("stale_commit.b1", 64'(rbusy[0]), 64'd1);
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         idle();
         we = 1'b1; waddr = 5'(i); wdata = 32'(i); wtag = (i == 1) ? 4'd7 : 4'(i);
         #1 chk($sformatf("drain%0d.cnt", i), 64'(busy_cnt), 64'(32 - i));
      end
      @(negedge clk);
      idle();
      raddr = {5'd31, 5'd1};
      #1 check_ports("drained", 32'h1, 1'b0, 4'd7, 32'd31, 1'b0, 4'd15, 6'd0);

      // Reset mid-run overrides a same-cycle commit and issue.
      @(negedge clk);
      rst = 1'b1;
      we = 1'b1; waddr = 5'd5; wdata = 32'h1111; wtag = 4'd0;
      iss_valid = 1'b1; iss_rd = 5'd8; iss_tag = 4'd3;
      raddr = {5'd9, 5'd5};
      #1 check_ports("rst_mid", 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 6'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      raddr = {5'd8, 5'd5};
      #1 check_ports("post_rst", 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 6'd0);
      raddr = {5'd31, 5'd9};
      #1 check_ports("post_rst2", 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 6'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
